// File: rtl/step_tick_gen.sv
// Step-enable generator: free-running prescaler in auto mode, synchronised and
// debounced pushbutton in manual mode, plus debounced level and phase outputs.
module step_tick_gen #(
    parameter int DIV       = 50000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic iMode,
    input  logic iBtn,
    input  logic iPause,
    output logic oTick,
    output logic oBtnLevel,
    output logic oPhase
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    // The sample that leaves S_LOW/S_HIGH is the first stable one, so the
    // counter in S_RISE/S_FALL only needs to cover the remaining DB_CYCLES-1.
    localparam logic [DW-1:0] DB_LAST = DW'((DB_CYCLES > 1) ? DB_CYCLES - 2 : 0);
    localparam bit DB_SINGLE = (DB_CYCLES == 1);

    typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;

    logic          r_sync1, r_sync2;
    logic          r_mode;
    logic [PW-1:0] r_presc;
    logic [DW-1:0] r_db_cnt;
    state_t        r_state;
    logic          r_tick, r_btn_level, r_phase;

    logic          w_btn_s;
    state_t        w_state_nxt;
    logic [DW-1:0] w_db_cnt_nxt;
    logic          w_press, w_level_nxt;
    logic          w_switch, w_auto_evt;
    logic [PW-1:0] w_presc_nxt;

    assign w_btn_s = r_sync2;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_mode  <= 1'b0;
            r_presc <= '0;
        end else begin
            r_sync1 <= iBtn;
            r_sync2 <= r_sync1;
            r_mode  <= iMode;
            r_presc <= w_presc_nxt;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_LOW;
            r_db_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_db_cnt <= w_db_cnt_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_db_cnt_nxt = r_db_cnt;
        case (r_state)
            S_LOW: begin
                if (w_btn_s) begin
                    w_state_nxt  = DB_SINGLE ? S_HIGH : S_RISE;
                    w_db_cnt_nxt = '0;
                end
            end
            S_RISE: begin
                if (!w_btn_s) begin
                    w_state_nxt  = S_LOW;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt  = S_HIGH;
                    w_db_cnt_nxt = '0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (!w_btn_s) begin
                    w_state_nxt  = DB_SINGLE ? S_LOW : S_FALL;
                    w_db_cnt_nxt = '0;
                end
            end
            S_FALL: begin
                if (w_btn_s) begin
                    w_state_nxt  = S_HIGH;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt  = S_LOW;
                    w_db_cnt_nxt = '0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt  = S_LOW;
                w_db_cnt_nxt = '0;
            end
        endcase
    end

    // Press is only the debounced rising acceptance, not a bounce back from S_FALL.
    always_comb begin
        w_level_nxt = (w_state_nxt == S_HIGH) || (w_state_nxt == S_FALL);
        w_press     = (w_state_nxt == S_HIGH) && ((r_state == S_LOW) || (r_state == S_RISE));
    end

    assign w_switch   = iMode ^ r_mode;
    assign w_auto_evt = !r_mode && !iPause && (r_presc == PRESC_LAST);

    always_comb begin
        w_presc_nxt = r_presc;
        if (w_switch || r_mode)
            w_presc_nxt = '0;
        else if (!iPause)
            w_presc_nxt = (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_tick      <= 1'b0;
            r_btn_level <= 1'b0;
            r_phase     <= 1'b0;
        end else begin
            r_tick      <= !w_switch && (r_mode ? w_press : w_auto_evt);
            r_btn_level <= w_level_nxt;
            if (!w_switch && w_auto_evt)
                r_phase <= ~r_phase;
        end
    end

    assign oTick     = r_tick;
    assign oBtnLevel = r_btn_level;
    assign oPhase    = r_phase;

endmodule

// File: tb/tb_step_tick_gen.sv
// Directed bench for step_tick_gen with DIV=4, DB_CYCLES=3: auto ticks, pause,
// button debounce, bounce rejection, mode switching and mid-debounce reset.
module tb_step_tick_gen;

    logic CLK, rst_n, iMode, iBtn, iPause;
    logic oTick, oBtnLevel, oPhase;

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic exp_phase;
    logic bounce_pat [0:5];

    step_tick_gen #(.DIV(4), .DB_CYCLES(3)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .iMode     (iMode),
        .iBtn      (iBtn),
        .iPause    (iPause),
        .oTick     (oTick),
        .oBtnLevel (oBtnLevel),
        .oPhase    (oPhase)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then land on the falling edge for sampling/driving.
    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        rst_n = 1'b0; iMode = 1'b0; iBtn = 1'b0; iPause = 1'b0;
        #1;
        check("rst_tick", oTick, 0);
        check("rst_level", oBtnLevel, 0);
        check("rst_phase", oPhase, 0);
        repeat (2) cyc();
        rst_n = 1'b1;

        // Free-running auto ticks on edges 4, 8, 12
        exp_phase = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            cyc();
            if (e % 4 == 0) exp_phase = ~exp_phase;
            check($sformatf("auto_tick[%0d]", e), oTick, (e % 4 == 0));
            check($sformatf("auto_phase[%0d]", e), oPhase, exp_phase);
        end

        // Pause for 3 cycles at count 2: tick slips from edge 16 to 19
        repeat (2) begin cyc(); check("pre_pause_tick", oTick, 0); end
        iPause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("pause_tick[%0d]", k), oTick, 0);
            check($sformatf("pause_phase[%0d]", k), oPhase, 1);
        end
        iPause = 1'b0;
        cyc(); check("resume_tick0", oTick, 0);
        cyc(); check("resume_tick1", oTick, 1);
        check("resume_phase", oPhase, 0);

        // Switch to manual at count 2: no tick, prescaler parked at 0
        repeat (2) begin cyc(); check("pre_switch_tick", oTick, 0); end
        iMode = 1'b1;
        cyc(); check("switch_edge_tick", oTick, 0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check($sformatf("manual_idle_tick[%0d]", k), oTick, 0);
            check($sformatf("manual_idle_phase[%0d]", k), oPhase, 0);
        end
        check("manual_presc_zero", 32'(dut.r_presc), 0);

        // Clean press: level up on edge 5 with one tick, down 5 edges after release
        iBtn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            check($sformatf("press_level[%0d]", k), oBtnLevel, (k >= 5));
            check($sformatf("press_tick[%0d]", k), oTick, (k == 5));
        end
        iBtn = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check($sformatf("release_level[%0d]", k), oBtnLevel, (k < 5));
            check($sformatf("release_tick[%0d]", k), oTick, 0);
        end

        // Bounce never holds long enough to be accepted
        bounce_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            iBtn = bounce_pat[k];
            cyc();
            check($sformatf("bounce_level[%0d]", k), oBtnLevel, 0);
            check($sformatf("bounce_tick[%0d]", k), oTick, 0);
        end
        iBtn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("bounce_tail_level[%0d]", k), oBtnLevel, 0);
            check($sformatf("bounce_tail_tick[%0d]", k), oTick, 0);
        end
        check("bounce_state_low", 32'(dut.r_state), 0);

        // Back to auto: first tick 4 edges after the mode register updates
        iMode = 1'b0;
        cyc(); check("back_switch_tick", oTick, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(); check($sformatf("back_tick[%0d]", k), oTick, 0);
        end
        cyc(); check("back_tick[4]", oTick, 1);
        check("back_phase", oPhase, 1);

        // Reset in S_RISE with db_cnt=1 discards progress
        iMode = 1'b1;
        iBtn  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc(); check($sformatf("pre_rst_tick[%0d]", k), oTick, 0);
        end
        check("pre_rst_state_rise", 32'(dut.r_state), 1);
        check("pre_rst_db_cnt", 32'(dut.r_db_cnt), 1);
        check("pre_rst_phase", oPhase, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tick", oTick, 0);
        check("mid_rst_level", oBtnLevel, 0);
        check("mid_rst_phase", oPhase, 0);
        check("mid_rst_state", 32'(dut.r_state), 0);
        @(negedge CLK);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            check($sformatf("post_rst_level[%0d]", k), oBtnLevel, (k >= 5));
            check($sformatf("post_rst_tick[%0d]", k), oTick, (k == 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
